// File: rtl/program_loader.sv
// Byte-serial program loader: assembles a length-prefixed byte stream into
// little-endian 32-bit words in a flat RAM image and holds the CPU in reset.
module program_loader #(
  parameter int unsigned RAM_SIZE = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [7:0]              byte_in,
  input  logic                    byte_valid,
  output logic                    byte_ready,
  output logic [RAM_SIZE*32-1:0]  ram,
  output logic                    cpu_reset,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam int unsigned WW = $clog2(RAM_SIZE + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [WW-1:0] word;
  logic [1:0]    idx;
  logic [7:0]    len;

  logic ready_d;
  logic busy_d;
  logic done_d;
  logic error_d;
  logic cpu_reset_d;

  logic loading_c;
  logic accept_c;
  logic last_c;
  logic clear_c;

  assign loading_c = (state == S_LEN) || (state == S_DATA);
  assign accept_c  = byte_valid && loading_c;
  assign last_c    = (state == S_DATA) && (idx == 2'd3) && (8'(word) == (len - 8'd1));
  assign clear_c   = start && !loading_c;

  // State register; outputs are registered copies of the decode of the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      byte_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      cpu_reset  <= 1'b1;
    end else begin
      state      <= state_nx;
      byte_ready <= ready_d;
      busy       <= busy_d;
      done       <= done_d;
      error      <= error_d;
      cpu_reset  <= cpu_reset_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start) state_nx = S_LEN;
      S_LEN: begin
        if (accept_c) begin
          if (byte_in == 8'd0)                 state_nx = S_DONE;
          else if (byte_in > 8'(RAM_SIZE))     state_nx = S_ERR;
          else                                 state_nx = S_DATA;
        end
      end
      S_DATA: if (accept_c && last_c) state_nx = S_DONE;
      S_DONE: if (start) state_nx = S_LEN;
      S_ERR:  if (start) state_nx = S_LEN;
      default: state_nx = S_IDLE;
    endcase
  end

  // Output decode of the next state
  always_comb begin
    ready_d     = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    error_d     = 1'b0;
    cpu_reset_d = 1'b1;
    case (state_nx)
      S_LEN, S_DATA: begin
        ready_d = 1'b1;
        busy_d  = 1'b1;
      end
      S_DONE: begin
        done_d      = 1'b1;
        cpu_reset_d = 1'b0;
      end
      S_ERR:   error_d = 1'b1;
      default: ready_d = 1'b0;
    endcase
  end

  // Datapath: length latch, byte/word counters and the RAM image
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram  <= '0;
      word <= '0;
      idx  <= '0;
      len  <= '0;
    end else if (clear_c) begin
      ram <= '0;
    end else if (accept_c && (state == S_LEN)) begin
      len  <= byte_in;
      word <= '0;
      idx  <= '0;
    end else if (accept_c && (state == S_DATA)) begin
      for (int unsigned k = 0; k < RAM_SIZE; k++) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if ((word == WW'(k)) && (idx == 2'(b))) ram[k*32 + b*8 +: 8] <= byte_in;
        end
      end
      idx <= idx + 2'd1;
      if (idx == 2'd3) word <= word + WW'(1);
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader against a byte-count
// reference model of the load protocol.
module tb_program_loader;

  localparam int unsigned RS = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [7:0]      byte_in;
  logic            byte_valid;
  logic            byte_ready;
  logic [RS*32-1:0] ram;
  logic            cpu_reset;
  logic            busy;
  logic            done;
  logic            error;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  program_loader #(.RAM_SIZE(RS)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .ram(ram),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Reference model: a load is "active" until 1 + 4N bytes have arrived
  bit          m_active;
  bit          m_len_known;
  int          m_n;
  int          m_cnt;
  bit          m_done;
  bit          m_err;
  logic [31:0] m_ram [RS];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active = 0; m_len_known = 0; m_n = 0; m_cnt = 0; m_done = 0; m_err = 0;
      for (int i = 0; i < RS; i++) m_ram[i] = '0;
    end else if (!m_active && start) begin
      for (int i = 0; i < RS; i++) m_ram[i] = '0;
      m_active = 1; m_len_known = 0; m_done = 0; m_err = 0;
    end else if (m_active && byte_valid) begin
      if (!m_len_known) begin
        if (byte_in == 0)            begin m_active = 0; m_done = 1; end
        else if (int'(byte_in) > RS) begin m_active = 0; m_err = 1; end
        else begin m_n = int'(byte_in); m_cnt = 0; m_len_known = 1; end
      end else begin
        m_ram[m_cnt / 4][8 * (m_cnt % 4) +: 8] = byte_in;
        m_cnt++;
        if (m_cnt == 4 * m_n) begin m_active = 0; m_done = 1; end
      end
    end
  end

  function automatic logic [RS*32-1:0] model_image();
    logic [RS*32-1:0] v;
    for (int i = 0; i < RS; i++) v[i*32 +: 32] = m_ram[i];
    return v;
  endfunction

  task automatic chk(input string name, input logic [RS*32-1:0] act, input logic [RS*32-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("byte_ready", 256'(byte_ready), 256'(m_active));
      chk("busy",       256'(busy),       256'(m_active));
      chk("done",       256'(done),       256'(m_done));
      chk("error",      256'(error),      256'(m_err));
      chk("cpu_reset",  256'(cpu_reset),  256'(!m_done));
      chk("ram",        ram,              model_image());
    end
  end

  task automatic drive(input bit s, input bit v, input logic [7:0] b);
    @(negedge clk);
    start = s; byte_valid = v; byte_in = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 8'($urandom));
  endtask

  task automatic send_stream(input logic [7:0] q[$], input bit throttle, input bit poke_start);
    foreach (q[i]) begin
      while (throttle && ($urandom_range(0, 2) == 0)) drive(0, 0, 8'($urandom));
      drive(poke_start && ($urandom_range(0, 3) == 0), 1, q[i]);
    end
    drive(0, 0, 8'h00);
  endtask

  logic [31:0] prog [7] = '{32'h000400AA, 32'h000401BB, 32'h00050200, 32'h00050301,
                             32'h00040002, 32'h000401DD, 32'h00030000};

  function automatic void build_prog(output logic [7:0] q[$]);
    q = {};
    q.push_back(8'd7);
    for (int w = 0; w < 7; w++)
      for (int b = 0; b < 4; b++) q.push_back(prog[w][8*b +: 8]);
  endfunction

  task automatic check_prog_literals(input string tag);
    chk({tag, "_w0"}, 256'(ram[31:0]),    256'(32'h000400AA));
    chk({tag, "_w6"}, 256'(ram[223:192]), 256'(32'h00030000));
    chk({tag, "_w7"}, 256'(ram[255:224]), 256'(0));
    chk({tag, "_model_w1"}, 256'(m_ram[1]), 256'(32'h000401BB));
    chk({tag, "_done"},      256'(done),      256'(1));
    chk({tag, "_cpu_reset"}, 256'(cpu_reset), 256'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    int n;
    reset = 1'b1; start = 0; byte_valid = 0; byte_in = 0;
    #1;
    chk("rst_cpu_reset",  256'(cpu_reset),  256'(1));
    chk("rst_byte_ready", 256'(byte_ready), 256'(0));
    chk("rst_ram",        ram,              '0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;

    // Full program, back-to-back; send_stream ends on the cycle after the last accept
    build_prog(q);
    drive(1, 0, 0);
    send_stream(q, 0, 0);
    @(negedge clk);
    check_prog_literals("full");

    // start in DONE releases nothing and clears the image next cycle
    drive(1, 0, 0);
    @(negedge clk);
    chk("restart_cpu_reset", 256'(cpu_reset), 256'(1));
    chk("restart_ram",       ram,              '0);

    // Throttled stream with start pokes mid-load
    send_stream(q, 1, 1);
    @(negedge clk);
    check_prog_literals("throttled");

    // Empty image
    drive(1, 0, 0);
    q = {8'd0};
    send_stream(q, 0, 0);
    @(negedge clk);
    chk("empty_done",  256'(done),       256'(1));
    chk("empty_ready", 256'(byte_ready), 256'(0));
    chk("empty_ram",   ram,              '0);

    // Oversize length, ignored trailing bytes, then a good reload
    drive(1, 0, 0);
    q = {8'd9, 8'h11, 8'h22, 8'h33};
    send_stream(q, 0, 0);
    @(negedge clk);
    chk("over_error",     256'(error),     256'(1));
    chk("over_cpu_reset", 256'(cpu_reset), 256'(1));
    chk("over_ram",       ram,             '0);
    build_prog(q);
    drive(1, 0, 0);
    send_stream(q, 1, 0);
    @(negedge clk);
    chk("reload_error", 256'(error), 256'(0));
    check_prog_literals("reload");

    // Reset after 6 data bytes of a 5-word load
    drive(1, 0, 0);
    q = {8'd5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    foreach (q[i]) drive(0, 1, q[i]);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_ram",       ram,             '0);
    chk("midrst_cpu_reset", 256'(cpu_reset), 256'(1));
    chk("midrst_busy",      256'(busy),      256'(0));
    @(negedge clk);
    reset = 1'b0; byte_valid = 0;

    // Randomized loads, including empty and oversize lengths
    for (int it = 0; it < 30; it++) begin
      n = $urandom_range(0, RS + 2);
      q = {8'(n)};
      for (int i = 0; i < ((n <= RS) ? 4 * n : 3); i++) q.push_back(8'($urandom));
      drive(1, 0, 0);
      send_stream(q, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      idle($urandom_range(0, 3));
    end

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
